// File: rtl/kbonacci_pkg.sv
// Shared types and helpers for the order-K recurrence generator.
package kbonacci_pkg;

  // Generator states: RUN streams terms, HALT parks after an unwrapped overflow.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Legal bounds for the recurrence order K.
  localparam int ORDER_MIN = 2;
  localparam int ORDER_MAX = 8;

  // True when K is inside the supported range.
  function automatic bit order_legal(input int k);
    return (k >= ORDER_MIN) && (k <= ORDER_MAX);
  endfunction

  // Width that holds the sum of K terms of dw bits without loss.
  function automatic int sum_width(input int dw, input int k);
    return dw + $clog2(k);
  endfunction

endpackage

// File: rtl/kbonacci_seq_gen_if.sv
// Control inputs and output stream of the K-bonacci generator.
interface kbonacci_seq_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 16
);
  logic                  load;
  logic [DATA_WIDTH-1:0] seed_val;
  logic                  wrap_mode;
  logic [DATA_WIDTH-1:0] out;
  logic [IDX_WIDTH-1:0]  out_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic                  ovf;
  logic                  halted;

  // Generator side: produces the stream and status.
  modport master (
    input  load, seed_val, wrap_mode, out_ready,
    output out, out_idx, out_valid, ovf, halted
  );

  // Consumer/controller side.
  modport slave (
    output load, seed_val, wrap_mode, out_ready,
    input  out, out_idx, out_valid, ovf, halted
  );
endinterface

// File: rtl/kbonacci_sum.sv
// Combinational K-input adder: truncated sum plus carry-out indication.
module kbonacci_sum
  import kbonacci_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ORDER      = 2
) (
  input  logic [DATA_WIDTH-1:0] terms_i [ORDER],
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  carry_o
);
  localparam int SUM_W = sum_width(DATA_WIDTH, ORDER);

  // Running partial sums; stage gi+1 adds term gi to stage gi.
  logic [SUM_W-1:0] partial [ORDER+1];

  assign partial[0] = '0;

  for (genvar gi = 0; gi < ORDER; gi++) begin : g_acc
    assign partial[gi+1] = partial[gi] + {{(SUM_W-DATA_WIDTH){1'b0}}, terms_i[gi]};
  end

  assign sum_o   = partial[ORDER][DATA_WIDTH-1:0];
  assign carry_o = |partial[ORDER][SUM_W-1:DATA_WIDTH];

endmodule

// File: rtl/kbonacci_seq_gen.sv
// Order-K recurrence stream source with seed load, overflow policy,
// sticky overflow flag and term index.
module kbonacci_seq_gen
  import kbonacci_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ORDER      = 2,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                resetn,
  kbonacci_seq_gen_if.master  bus
);

  if (!order_legal(ORDER)) begin : g_order_check
    $error("kbonacci_seq_gen: ORDER must lie in 2..8");
  end

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] h_q [ORDER];
  logic [DATA_WIDTH-1:0] h_d [ORDER];
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  ovf_q, ovf_d;
  logic                  valid_q, valid_d;

  logic [DATA_WIDTH-1:0] sum;
  logic                  carry;

  kbonacci_sum #(
    .DATA_WIDTH (DATA_WIDTH),
    .ORDER      (ORDER)
  ) u_sum (
    .terms_i (h_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  wire advance = (state_q == RUN) && valid_q && bus.out_ready;

  // Next-state: load beats handshake; an advance either shifts or halts.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (bus.load) begin
      for (int i = 1; i < ORDER; i++) h_d[i] = '0;
      h_d[0]  = bus.seed_val;
      idx_d   = '0;
      ovf_d   = 1'b0;
      state_d = RUN;
    end else if (advance) begin
      if (carry && !bus.wrap_mode) begin
        // Keep the last term visible; the stream stops here.
        ovf_d   = 1'b1;
        state_d = HALT;
      end else begin
        for (int i = ORDER - 1; i > 0; i--) h_d[i] = h_q[i-1];
        h_d[0] = sum;
        idx_d  = idx_q + IDX_WIDTH'(1);
        if (carry) ovf_d = 1'b1;
      end
    end
    // Valid is a register so it never follows out_ready combinationally.
    valid_d = (state_d == RUN);
  end

  // State, history, index and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RUN;
      for (int i = 1; i < ORDER; i++) h_q[i] <= '0;
      h_q[0]  <= DATA_WIDTH'(1);
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out       = h_q[0];
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.halted    = (state_q == HALT);

endmodule

// File: tb/tb_kbonacci_seq_gen.sv
// Directed bench: Fibonacci/Tribonacci at 32 bits, overflow halt/wrap at 8 bits.
module tb_kbonacci_seq_gen;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  kbonacci_seq_gen_if #(.DATA_WIDTH(32), .IDX_WIDTH(16)) if2 ();
  kbonacci_seq_gen_if #(.DATA_WIDTH(32), .IDX_WIDTH(16)) if3 ();
  kbonacci_seq_gen_if #(.DATA_WIDTH(8),  .IDX_WIDTH(16)) if8 ();

  kbonacci_seq_gen #(.DATA_WIDTH(32), .ORDER(2), .IDX_WIDTH(16)) dut2 (
    .clk(clk), .resetn(resetn), .bus(if2.master));
  kbonacci_seq_gen #(.DATA_WIDTH(32), .ORDER(3), .IDX_WIDTH(16)) dut3 (
    .clk(clk), .resetn(resetn), .bus(if3.master));
  kbonacci_seq_gen #(.DATA_WIDTH(8),  .ORDER(2), .IDX_WIDTH(16)) dut8 (
    .clk(clk), .resetn(resetn), .bus(if8.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] fib2 [5];
    logic [31:0] trib [8];
    logic [7:0]  fib8 [13];
    fib2 = '{1, 1, 2, 3, 5};
    trib = '{1, 1, 2, 4, 7, 13, 24, 44};
    fib8 = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    errors = 0;
    checks = 0;

    resetn = 1'b0;
    if2.load = 0; if2.seed_val = '0; if2.wrap_mode = 1; if2.out_ready = 0;
    if3.load = 0; if3.seed_val = '0; if3.wrap_mode = 1; if3.out_ready = 0;
    if8.load = 0; if8.seed_val = '0; if8.wrap_mode = 0; if8.out_ready = 0;
    step();
    step();
    chk("rst_out", if2.out, 1);
    chk("rst_valid", if2.out_valid, 0);
    chk("rst_idx", if2.out_idx, 0);
    chk("rst_ovf", if2.ovf, 0);
    chk("rst_halted", if2.halted, 0);
    $display("reset: out=%0d valid=%0d idx=%0d", if2.out, if2.out_valid, if2.out_idx);

    resetn = 1'b1;
    step();
    chk("run_valid", if2.out_valid, 1);

    // Fibonacci with ready held high
    if2.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fib_out%0d", i), if2.out, fib2[i]);
      chk($sformatf("fib_idx%0d", i), if2.out_idx, i);
      $display("fib: idx=%0d out=%0d", if2.out_idx, if2.out);
      if (i < 4) step();
    end

    // Backpressure for three cycles after term 5
    if2.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out", if2.out, 5);
      chk("bp_idx", if2.out_idx, 4);
      chk("bp_valid", if2.out_valid, 1);
      $display("backpressure: idx=%0d out=%0d", if2.out_idx, if2.out);
    end
    if2.out_ready = 1;
    step();
    chk("resume_out", if2.out, 8);
    chk("resume_idx", if2.out_idx, 5);
    step();
    chk("resume2_out", if2.out, 13);
    chk("resume2_idx", if2.out_idx, 6);
    $display("resume: idx=%0d out=%0d", if2.out_idx, if2.out);

    // Load seed 5 while ready=1: the presented 13 is dropped
    if2.load = 1;
    if2.seed_val = 32'd5;
    step();
    if2.load = 0;
    begin
      logic [31:0] seeded [5];
      seeded = '{5, 5, 10, 15, 25};
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("load_out%0d", i), if2.out, seeded[i]);
        chk($sformatf("load_idx%0d", i), if2.out_idx, i);
        $display("seeded: idx=%0d out=%0d", if2.out_idx, if2.out);
        if (i < 4) step();
      end
    end

    // Mid-run reset
    resetn = 1'b0;
    step();
    chk("midrst_out", if2.out, 1);
    chk("midrst_idx", if2.out_idx, 0);
    chk("midrst_valid", if2.out_valid, 0);
    $display("mid-run reset: out=%0d idx=%0d", if2.out, if2.out_idx);
    if2.out_ready = 0;
    resetn = 1'b1;
    step();

    // Tribonacci
    if3.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("trib_out%0d", i), if3.out, trib[i]);
      chk($sformatf("trib_idx%0d", i), if3.out_idx, i);
      $display("trib: idx=%0d out=%0d", if3.out_idx, if3.out);
      if (i < 7) step();
    end
    if3.out_ready = 0;

    // 8-bit, halt on overflow
    if8.out_ready = 1;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("w8_out%0d", i), if8.out, fib8[i]);
      chk($sformatf("w8_idx%0d", i), if8.out_idx, i);
      $display("w8: idx=%0d out=%0d", if8.out_idx, if8.out);
      if (i < 12) step();
    end
    chk("w8_pre_ovf", if8.ovf, 0);
    step();
    chk("halt_ovf", if8.ovf, 1);
    chk("halt_halted", if8.halted, 1);
    chk("halt_valid", if8.out_valid, 0);
    chk("halt_out", if8.out, 233);
    chk("halt_idx", if8.out_idx, 12);
    step();
    chk("halt_hold_out", if8.out, 233);
    chk("halt_hold_halted", if8.halted, 1);
    $display("halt: out=%0d ovf=%0d halted=%0d", if8.out, if8.ovf, if8.halted);

    // Restart via load, now in wrap mode
    if8.load = 1;
    if8.seed_val = 8'd1;
    if8.wrap_mode = 1;
    step();
    if8.load = 0;
    chk("reload_out", if8.out, 1);
    chk("reload_idx", if8.out_idx, 0);
    chk("reload_ovf", if8.ovf, 0);
    chk("reload_halted", if8.halted, 0);
    chk("reload_valid", if8.out_valid, 1);
    $display("reload: out=%0d ovf=%0d", if8.out, if8.ovf);
    for (int i = 1; i <= 12; i++) step();
    chk("wrap_pre_out", if8.out, 233);
    step();
    chk("wrap1_out", if8.out, 121);
    chk("wrap1_idx", if8.out_idx, 13);
    chk("wrap1_ovf", if8.ovf, 1);
    chk("wrap1_valid", if8.out_valid, 1);
    $display("wrap: idx=%0d out=%0d ovf=%0d", if8.out_idx, if8.out, if8.ovf);
    step();
    chk("wrap2_out", if8.out, 98);
    chk("wrap2_idx", if8.out_idx, 14);
    chk("wrap2_valid", if8.out_valid, 1);
    $display("wrap: idx=%0d out=%0d ovf=%0d", if8.out_idx, if8.out, if8.ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbonacci_seq_gen.md
Name: kbonacci_seq_gen

Overview:
Parametrised successor to the team's single-width Fibonacci generator. Produces the order-K recurrence F(n) = F(n-1) + … + F(n-K), with K=2 giving Fibonacci and K=3 giving Tribonacci. Output uses a valid/ready stream with backpressure. Adds runtime seed load, selectable overflow policy (wrap or halt), a sticky overflow flag and a term index. Sits as a stream source feeding test-pattern and checker pipelines.

Parameters:
DATA_WIDTH, 32, width of each term
ORDER, 2, recurrence order K; legal range 2..8; elaboration error otherwise
IDX_WIDTH, 16, width of term index counter

Ports:
clk  in  1  clock
resetn  in  1  reset; one clock; reset is synchronous and active-low
load  in  1  single-cycle pulse: restart sequence from seed_val
seed_val  in  DATA_WIDTH  first term used on load; must be nonzero for a meaningful sequence
wrap_mode  in  1  1 = wrap modulo 2^DATA_WIDTH on overflow; 0 = halt on overflow
out  out  DATA_WIDTH  current term
out_idx  out  IDX_WIDTH  index n of current term
out_valid  out  1  current term is available
out_ready  in  1  consumer accepts term
ovf  out  1  sticky: a sum exceeded DATA_WIDTH bits since last reset/load
halted  out  1  high in HALT state

Behaviour:
- History registers h[0..K-1], with h[0] newest; out = h[0].
- Reset (resetn=0 at posedge), highest priority:
  - h[0]=1, h[1..K-1]=0, out=1, out_idx=0, ovf=0, state=RUN.
  - out_valid=0 while resetn low.
- Load (load=1, resetn=1) has priority over handshake:
  - h[0]=seed_val, others 0, out_idx=0, ovf=0, state=RUN.
  - A term presented in the load cycle is discarded even if out_ready=1; it is not replayed.
- States: RUN, HALT.
  - RUN: out_valid=1.
  - HALT: out_valid=0, halted=1, out/out_idx hold the last emitted term.
  - HALT exits only on reset or load.
- Advance occurs only on out_valid && out_ready in RUN:
  - sum = h[0]+…+h[K-1], computed at DATA_WIDTH+clog2(K) bits.
  - carry = (upper bits of sum != 0).
  - No carry: shift history (h[i] <= h[i-1]), h[0] <= sum[DATA_WIDTH-1:0], out_idx++.
  - Carry, wrap_mode=1: same shift with truncated sum; ovf<=1.
  - Carry, wrap_mode=0: history unchanged, ovf<=1, state<=HALT.
- Latency and backpressure:
  - Next term appears on out the cycle after the handshake.
  - One term per cycle when out_ready is held high.
  - out_ready=0: out, out_idx and the history hold; no lost terms.
- Sequence from reset: 1,1,2,3,5,… for K=2; 1,1,2,4,7,13,… for K=3.
- out_idx wraps modulo 2^IDX_WIDTH silently; this does not affect ovf.
- wrap_mode is sampled only at advance cycles; changing it mid-run is legal.
- out_valid must not depend combinationally on out_ready.
- All outputs are registered except halted, which is decoded from state.

Decomposition:
- Package kbonacci_pkg: state enum {RUN, HALT}; localparam SUM_W = DATA_WIDTH + $clog2(ORDER); ORDER range check constant.
- One sub-module, kbonacci_sum: combinational K-input adder returning the truncated sum and the carry flag.
- FSM, history shift register and index counter stay in the top module.

Test Plan:
- Reset, then out_ready=1 continuously (K=2, W=32) -> out 1,1,2,3,5,8,13 with out_idx 0..6; out=1 and out_valid=0 during reset.
- Backpressure: drop out_ready for 3 cycles after term 5 -> out holds 5, out_idx holds 4; resumes with 8, no skip or duplicate.
- K=3, W=32 -> 1,1,2,4,7,13,24,44.
- W=8, K=2, wrap_mode=0 -> last term 233 at idx 12; next advance sets ovf=1, halted=1, out_valid=0, out stays 233; load with seed 1 restarts at 1, ovf=0.
- W=8, K=2, wrap_mode=1 -> after 233 comes 121 (377 mod 256) with ovf=1, then 98 (354 mod 256); out_valid stays 1.
- Load seed_val=5 mid-run with simultaneous out_ready=1 -> next terms 5,5,10,15,25 at idx 0..; resetn=0 mid-run -> out=1, idx=0 on the next cycle.
